// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with active-low request/grant lines,
// one cycle of registered grant latency, and an optional tenure limit that
// preempts a long-holding master unless it holds the bus lock.
module bus_arbiter_rr #(
  parameter int unsigned MAX_TENURE = 16,  // 0 disables preemption
  parameter int unsigned CNT_W      = 5    // 2**CNT_W must exceed MAX_TENURE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       bus_lock_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       bus_busy
);

  localparam int unsigned N_MASTERS = 4;
  localparam logic [CNT_W-1:0] TENURE_MAX = CNT_W'(MAX_TENURE);
  localparam logic PREEMPT_EN = (MAX_TENURE != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [N_MASTERS-1:0]   r_grnt_n;
  logic [1:0]             r_owner;
  logic [1:0]             r_last;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_cnt;

  logic [N_MASTERS-1:0]   w_req;
  logic [N_MASTERS-1:0]   w_owner_oh;
  logic [N_MASTERS-1:0]   w_others;
  logic                   w_found;
  logic [1:0]             w_win;
  logic [1:0]             w_idx;
  logic                   w_preempt;
  logic [N_MASTERS-1:0]   w_win_grnt_n;

  // Active-high request vector and the competitors of the current owner
  assign w_req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_owner_oh   = 4'b0001 << r_owner;
  assign w_others     = w_req & ~w_owner_oh;
  assign w_win_grnt_n = ~(4'b0001 << w_win);

  // Tenure expired with a competitor waiting and no lock held
  assign w_preempt = PREEMPT_EN && (r_cnt == TENURE_MAX) && (|w_others) && bus_lock_;

  // Round-robin search starting just after the last owner, wrapping upward
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_idx = r_last + 2'(i + 1);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Arbitration state machine; all outputs are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_grnt_n <= '1;
      r_owner  <= 2'd0;
      r_last   <= 2'd3;   // master 0 gets first priority after reset
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_OWNED: begin
          if (w_req[r_owner]) begin
            if (w_preempt) begin
              // Drop the grant for one gap cycle; owner stays last in rotation
              r_state  <= ST_GAP;
              r_grnt_n <= '1;
              r_busy   <= 1'b0;
              r_cnt    <= '0;
            end else if (r_cnt < TENURE_MAX) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (w_found) begin
            // Owner released: direct handover without a gap
            r_state  <= ST_OWNED;
            r_grnt_n <= w_win_grnt_n;
            r_owner  <= w_win;
            r_last   <= w_win;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_state  <= ST_IDLE;
            r_grnt_n <= '1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
          end
        end
        default: begin
          // IDLE and GAP arbitrate identically
          if (w_found) begin
            r_state  <= ST_OWNED;
            r_grnt_n <= w_win_grnt_n;
            r_owner  <= w_win;
            r_last   <= w_win;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_state  <= ST_IDLE;
            r_grnt_n <= '1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
          end
        end
      endcase
    end
  end

  assign m0_grnt_ = r_grnt_n[0];
  assign m1_grnt_ = r_grnt_n[1];
  assign m2_grnt_ = r_grnt_n[2];
  assign m3_grnt_ = r_grnt_n[3];
  assign owner    = r_owner;
  assign bus_busy = r_busy;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: one instance with a short tenure limit
// and one with preemption disabled, sharing the same request stimulus.
module tb_bus_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_n;
  logic       lock_n;

  logic [3:0] grnt_a;
  logic [1:0] owner_a;
  logic       busy_a;
  logic [3:0] grnt_b;
  logic [1:0] owner_b;
  logic       busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  bus_arbiter_rr #(.MAX_TENURE(4), .CNT_W(3)) u_dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .m0_req_   (req_n[0]),
    .m1_req_   (req_n[1]),
    .m2_req_   (req_n[2]),
    .m3_req_   (req_n[3]),
    .bus_lock_ (lock_n),
    .m0_grnt_  (grnt_a[0]),
    .m1_grnt_  (grnt_a[1]),
    .m2_grnt_  (grnt_a[2]),
    .m3_grnt_  (grnt_a[3]),
    .owner     (owner_a),
    .bus_busy  (busy_a)
  );

  bus_arbiter_rr #(.MAX_TENURE(0), .CNT_W(3)) u_dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .m0_req_   (req_n[0]),
    .m1_req_   (req_n[1]),
    .m2_req_   (req_n[2]),
    .m3_req_   (req_n[3]),
    .bus_lock_ (lock_n),
    .m0_grnt_  (grnt_b[0]),
    .m1_grnt_  (grnt_b[1]),
    .m2_grnt_  (grnt_b[2]),
    .m3_grnt_  (grnt_b[3]),
    .owner     (owner_b),
    .bus_busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges with the given requests, check idle outputs, release off-edge
  task automatic do_reset(input logic [3:0] req);
    rst_n  = 1'b0;
    req_n  = req;
    lock_n = 1'b1;
    #1;
    check("rst_grnt_async", 32'(grnt_a), 32'hF);
    repeat (2) tick();
    check("rst_grnt", 32'(grnt_a), 32'hF);
    check("rst_owner", 32'(owner_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] gvec(input int m);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m);
  endfunction

  initial begin
    rst_n  = 1'b0;
    req_n  = 4'hF;
    lock_n = 1'b1;
    tick();

    // Reset held with m1 requesting; first edge after release grants m1
    do_reset(4'b1101);
    tick();
    check("t1_grnt", 32'(grnt_a), 32'(gvec(1)));
    check("t1_owner", 32'(owner_a), 32'h1);
    check("t1_busy", 32'(busy_a), 32'h1);

    // m0 and m2 together: m0 first, then direct handover to m2
    do_reset(4'b1010);
    tick();
    check("t2_grnt_m0", 32'(grnt_a), 32'(gvec(0)));
    check("t2_owner_m0", 32'(owner_a), 32'h0);
    tick();
    check("t2_hold_m0", 32'(grnt_a), 32'(gvec(0)));
    req_n = 4'b1011;
    tick();
    check("t2_grnt_m2", 32'(grnt_a), 32'(gvec(2)));
    check("t2_owner_m2", 32'(owner_a), 32'h2);
    check("t2_busy_m2", 32'(busy_a), 32'h1);
    check("t2_b_grnt_m2", 32'(grnt_b), 32'(gvec(2)));

    // Asynchronous reset mid-ownership drops the grant without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t2_async_rst", 32'(grnt_a), 32'hF);

    // All four request with tenure 4: 4 cycles each, then one gap
    do_reset(4'b0000);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("t3_grnt", 32'(grnt_a), 32'(gvec(k % 4)));
        check("t3_owner", 32'(owner_a), 32'(k % 4));
      end
      tick();
      check("t3_gap_grnt", 32'(grnt_a), 32'hF);
      check("t3_gap_busy", 32'(busy_a), 32'h0);
    end

    // m3 holds lock past the tenure limit while m1 waits
    do_reset(4'b0111);
    tick();
    check("t4_grnt_m3", 32'(grnt_a), 32'(gvec(3)));
    lock_n = 1'b0;
    req_n  = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t4_locked_m3", 32'(grnt_a), 32'(gvec(3)));
    end
    lock_n = 1'b1;
    tick();
    check("t4_gap_grnt", 32'(grnt_a), 32'hF);
    check("t4_gap_busy", 32'(busy_a), 32'h0);
    check("t4_gap_owner", 32'(owner_a), 32'h3);
    tick();
    check("t4_grnt_m1", 32'(grnt_a), 32'(gvec(1)));
    check("t4_owner_m1", 32'(owner_a), 32'h1);

    // Preemption disabled: m2 holds 100 cycles while m0 waits
    do_reset(4'b1011);
    tick();
    check("t5_grnt_m2", 32'(grnt_b), 32'(gvec(2)));
    req_n = 4'b1010;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c % 10 == 9) check("t5_hold_m2", 32'(grnt_b), 32'(gvec(2)));
    end
    req_n = 4'b1110;
    tick();
    check("t5_grnt_m0", 32'(grnt_b), 32'(gvec(0)));
    check("t5_owner_m0", 32'(owner_b), 32'h0);

    // Single master: request, release, idle, request again
    do_reset(4'b1101);
    tick();
    check("t6_grnt1", 32'(grnt_a), 32'(gvec(1)));
    req_n = 4'b1111;
    tick();
    check("t6_idle_grnt", 32'(grnt_a), 32'hF);
    check("t6_idle_busy", 32'(busy_a), 32'h0);
    check("t6_idle_owner", 32'(owner_a), 32'h1);
    tick();
    check("t6_idle_owner2", 32'(owner_a), 32'h1);
    check("t6_idle_busy2", 32'(busy_a), 32'h0);
    req_n = 4'b1101;
    tick();
    check("t6_grnt2", 32'(grnt_a), 32'(gvec(1)));
    check("t6_busy2", 32'(busy_a), 32'h1);

    // A request withdrawn before the sampling edge is never granted
    req_n = 4'b1111;
    tick();
    check("t7_release", 32'(grnt_a), 32'hF);
    req_n = 4'b1110;
    #3;
    req_n = 4'b1111;
    tick();
    check("t7_no_grant", 32'(grnt_a), 32'hF);
    check("t7_owner", 32'(owner_a), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // At most one grant low on either instance at every sample point
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      check("onehot_a", 32'($countones(~grnt_a) <= 1), 32'h1);
      check("onehot_b", 32'($countones(~grnt_b) <= 1), 32'h1);
    end
  end

endmodule
